// File: rtl/data_mem_if.sv
// data_mem_if: the core's data-port bus.
//   daddr    : byte address from the core
//   data_in  : store data from the core
//   mem_en   : 1 = store this cycle
//   mem_data : combinational read data back to the core
// master = core side, slave = memory responder side.
interface data_mem_if;
    logic [31:0] daddr;
    logic [31:0] data_in;
    logic        mem_en;
    logic [31:0] mem_data;

    modport master (output daddr, output data_in, output mem_en, input mem_data);
    modport slave  (input daddr, input data_in, input mem_en, output mem_data);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's data port.
// Word-addressed RAM plus MMIO (cycle counter, 8-bit GPIO, store counter).
// After reset an init FSM clears the RAM and holds the core in reset.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   bus       : data_mem_if.slave (daddr, data_in, mem_en in; mem_data out)
//   core_rst  : active-high reset to the core, 1 while in reset or clearing
//   init_done : 1 once the RAM clear has finished
//   gpio_out  : GPIO register contents
// Optional: define DMEM_WRITE_FWD_EN for write-first reads (data_in is
// forwarded to mem_data on a same-cycle write to RAM or GPIO).
module data_mem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus,
    output logic       core_rst,
    output logic       init_done,
    output logic [7:0] gpio_out
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_idx;
    logic [31:0]   cycle_cnt;
    logic [15:0]   store_cnt;
    logic [31:0]   ram [MEM_WORDS];

    // Address decode
    logic          sel_mmio;
    logic [1:0]    mmio_off;
    logic [AW-1:0] word_idx;
    logic          ram_wr, gpio_wr;

    assign sel_mmio = bus.daddr[31];
    assign mmio_off = bus.daddr[3:2];
    assign word_idx = bus.daddr[AW+1:2];
    assign ram_wr   = (state == RUN) && bus.mem_en && !sel_mmio;
    assign gpio_wr  = (state == RUN) && bus.mem_en && sel_mmio && (mmio_off == 2'd1);

    // Upper RAM address bits alias; byte offset is ignored.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.daddr[30:AW+2], bus.daddr[1:0]};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nxt;
    end

    // FSM next state: leave CLEAR on the edge that writes the last word
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == AW'(MEM_WORDS-1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Registered status; updates on the same edge as the state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst  <= 1'b1;
            init_done <= 1'b0;
        end else begin
            core_rst  <= (state_nxt == CLEAR);
            init_done <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end

    // RAM write port: clear sweep, or core store in RUN
    always_ff @(posedge clk) begin
        if (state == CLEAR) ram[clr_idx]  <= 32'h0;
        else if (ram_wr)    ram[word_idx] <= bus.data_in;
    end

    // MMIO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
            gpio_out  <= 8'h00;
        end else begin
            if (state == RUN) cycle_cnt <= cycle_cnt + 1'b1;
            if (ram_wr && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 1'b1;
            if (gpio_wr) gpio_out <= bus.data_in[7:0];
        end
    end

    // Combinational read path; 0 while clearing
    always_comb begin
        bus.mem_data = 32'h0;
        if (state == RUN) begin
            if (!sel_mmio) begin
                bus.mem_data = ram[word_idx];
`ifdef DMEM_WRITE_FWD_EN
                if (bus.mem_en) bus.mem_data = bus.data_in;
`endif
            end else begin
                case (mmio_off)
                    2'd0: bus.mem_data = cycle_cnt;
                    2'd1: begin
                        bus.mem_data = {24'h0, gpio_out};
`ifdef DMEM_WRITE_FWD_EN
                        if (bus.mem_en) bus.mem_data = {24'h0, bus.data_in[7:0]};
`endif
                    end
                    2'd2:    bus.mem_data = {16'h0, store_cnt};
                    default: bus.mem_data = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder.
// Expected read data is queued when a read is driven and popped when the
// combinational output is sampled.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       core_rst, init_done;
    logic [7:0] gpio_out;

    data_mem_if bus ();

    data_mem_responder #(.MEM_WORDS(256), .AW(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .core_rst(core_rst), .init_done(init_done), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [15:0] sc_model = 16'h0;
    logic [31:0] c1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare against current mem_data
    task automatic sb_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty_q"}, 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.mem_data, e);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        @(negedge clk);
        bus.mem_en = 1'b0;
        bus.daddr  = a;
        exp_q.push_back(e);
        #2 sb_check(tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.daddr   = a;
        bus.data_in = d;
        bus.mem_en  = 1'b1;
        if (!a[31] && sc_model != 16'hFFFF) sc_model++;
        @(posedge clk);
        #1 bus.mem_en = 1'b0;
    endtask

    // Count clear cycles after rst rises, with stray stores on the bus
    task automatic run_clear(input string tag);
        for (int i = 0; i < 255; i++) begin
            @(posedge clk);
            #1;
            bus.daddr   = 32'h0000_0010;
            bus.data_in = 32'hFFFF_0000 | i;
            bus.mem_en  = (i % 7 == 0) && (i < 250);
        end
        bus.mem_en = 1'b0;
        chk({tag, "_core_rst_held"}, {31'h0, core_rst}, 32'h1);
        chk({tag, "_mem_data_clear"}, bus.mem_data, 32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_core_rst_rel"}, {31'h0, core_rst}, 32'h0);
        chk({tag, "_init_done"}, {31'h0, init_done}, 32'h1);
    endtask

    initial begin
        bus.daddr   = 32'h0;
        bus.data_in = 32'h0;
        bus.mem_en  = 1'b0;

        // Power-up
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_rst", {31'h0, core_rst}, 32'h1);
        chk("rst_init_done", {31'h0, init_done}, 32'h0);
        chk("rst_gpio", {24'h0, gpio_out}, 32'h0);
        chk("rst_mem_data", bus.mem_data, 32'h0);
        @(negedge clk) rst = 1'b1;
        run_clear("pwrup");
        for (int w = 0; w < 256; w++) rd("ram_zero", 32'(w) << 2, 32'h0);

        // RAM store/load and aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
        rd("ram_alias_hi", 32'h7FFF_FC12, 32'hDEAD_BEEF);
        rd("store_cnt1", 32'h8000_0008, {16'h0, sc_model});

        // MMIO
        wr(32'h8000_0004, 32'h0000_01A5);
        #1 chk("gpio_out", {24'h0, gpio_out}, 32'h0000_00A5);
        rd("gpio_rd", 32'h8000_0004, 32'h0000_00A5);
        wr(32'h8000_000C, 32'h1234_5678);
        rd("reserved_rd", 32'h8000_000C, 32'h0);
        wr(32'h8000_0008, 32'h0000_5555);
        rd("store_cnt_ro", 32'h8000_0008, {16'h0, sc_model});

        // cycle_cnt: write ignored, 5 cycles between samples
        @(negedge clk);
        bus.daddr = 32'h8000_0000;
        #2 c1 = bus.mem_data;
        @(negedge clk);
        bus.data_in = 32'h0;
        bus.mem_en  = 1'b1;
        @(negedge clk);
        bus.mem_en  = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(c1 + 32'd5);
        #2 sb_check("cycle_delta5");

        // Read-during-write
        wr(32'h0000_0020, 32'h1111_1111);
        @(negedge clk);
        bus.daddr   = 32'h0000_0020;
        bus.data_in = 32'h2222_2222;
        bus.mem_en  = 1'b1;
        sc_model++;
`ifdef DMEM_WRITE_FWD_EN
        exp_q.push_back(32'h2222_2222);
`else
        exp_q.push_back(32'h1111_1111);
`endif
        #2 sb_check("rdw_same_cycle");
        @(posedge clk);
        #1 bus.mem_en = 1'b0;
        rd("rdw_next", 32'h0000_0020, 32'h2222_2222);
        rd("store_cnt3", 32'h8000_0008, {16'h0, sc_model});

        // Reset in RUN
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("run_rst_core_rst", {31'h0, core_rst}, 32'h1);
        chk("run_rst_init_done", {31'h0, init_done}, 32'h0);
        chk("run_rst_gpio", {24'h0, gpio_out}, 32'h0);
        @(negedge clk) rst = 1'b1;
        // Reset again at clear index 100
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("clr_rst_core_rst", {31'h0, core_rst}, 32'h1);
        @(negedge clk) rst = 1'b1;
        sc_model = 16'h0;
        run_clear("reclr");
        rd("reclr_0x10", 32'h0000_0010, 32'h0);
        rd("reclr_0x20", 32'h0000_0020, 32'h0);
        rd("reclr_store_cnt", 32'h8000_0008, 32'h0);
        rd("reclr_gpio", 32'h8000_0004, 32'h0);

        // store_cnt saturation
        @(negedge clk);
        force dut.store_cnt = 16'hFFFE;
        #1 release dut.store_cnt;
        sc_model = 16'hFFFE;
        wr(32'h0000_0040, 32'hA);
        wr(32'h0000_0044, 32'hB);
        wr(32'h0000_0048, 32'hC);
        rd("store_cnt_sat", 32'h8000_0008, {16'h0, sc_model});
        rd("sat_ram", 32'h0000_0048, 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipelined core's data port. It answers the core's data address, write data and write enable, and returns read data.
- Contains word-addressed data RAM plus a small MMIO region: a cycle counter, an 8-bit GPIO register and a store counter.
- After reset, an init FSM clears the whole RAM. During clearing, the block holds the core in reset through core_rst, so the core never sees uninitialised memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit RAM words; power of two, min 4.
- AW, 8, word-index width; must equal log2(MEM_WORDS).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- daddr  in  32  byte address from the core's M stage.
- data_in  in  32  store data from the core (the core's data_out).
- mem_en  in  1  write enable from the core; 1 = store this cycle.
- mem_data  out  32  read data to the core's writeback mux; combinational.
- core_rst  out  1  active-high reset to the core; 1 while in reset or clearing.
- init_done  out  1  1 once the RAM clear has finished.
- gpio_out  out  8  MMIO GPIO register contents.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, clr_idx=0.
  - cycle_cnt=0, store_cnt=0, gpio_out=8'h00.
  - core_rst=1 and init_done=0 immediately. mem_data follows its decode, which gives 0 during CLEAR.
- FSM, two states:
  - CLEAR: each clock writes 32'h0 to RAM[clr_idx] and increments clr_idx. On the edge that writes clr_idx=MEM_WORDS-1, move to RUN. Clearing takes exactly MEM_WORDS cycles after rst rises.
  - RUN: terminal state. Left only by reset.
- core_rst and init_done are registered: core_rst=(state==CLEAR), init_done=(state==RUN). Both change on the same edge as the CLEAR->RUN transition.
- In CLEAR:
  - mem_en is ignored and no core write lands.
  - mem_data=0.
  - cycle_cnt is held at 0.
- Address decode, in RUN:
  - daddr[31]=0 selects RAM. Word index = daddr[AW+1:2]. Upper bits [30:AW+2] are ignored, so accesses alias/wrap modulo MEM_WORDS. daddr[1:0] is ignored; only word accesses are supported.
  - daddr[31]=1 selects MMIO, with offset daddr[3:2]:
    - 0: cycle_cnt, read-only; writes ignored.
    - 1: GPIO; read returns {24'h0, gpio_out}; write loads data_in[7:0].
    - 2: store_cnt; read returns zero-extended 16 bits; read-only.
    - 3: reserved; reads 0, writes ignored.
- Reads are combinational: mem_data is a pure function of daddr and current state, valid in the same cycle, with 0 added latency. The core captures it on the next edge.
- Writes: on the rising edge when state==RUN and mem_en=1, the decoded target is updated. A RAM write also increments store_cnt, which saturates at 16'hFFFF and does not wrap.
- cycle_cnt: 32-bit. Increments every clock in RUN and wraps 32'hFFFFFFFF -> 0.
- Read-during-write to the same RAM word (macro off): mem_data returns the old contents; the new value is visible from the next cycle.
- Reset mid-CLEAR or mid-RUN: restart from CLEAR with clr_idx=0. RAM is fully re-cleared and the core is held again.
- No X on any output after reset. mem_data for MMIO and reserved offsets is fully defined.

Optional Feature:
- Macro DMEM_WRITE_FWD_EN.
- When defined: in RUN, if mem_en=1 and daddr hits a RAM word (daddr[31]=0), mem_data returns data_in combinationally (write-first). A write to GPIO likewise returns {24'h0, data_in[7:0]} on a same-cycle read.
- When undefined: read-first behaviour as described above. No extra mux in the read path.

Test Plan:
- Power-up: rst=0 for 3 cycles, then 1 -> core_rst=1 for exactly 256 cycles after rst rises, then core_rst=0 and init_done=1. Reading all 256 words returns 32'h0.
- RAM store/load: write 32'hDEADBEEF to daddr 32'h0000_0010 with mem_en=1. Next cycle, daddr=0x10 -> mem_data=32'hDEADBEEF; daddr 0x410 (alias) -> same value; store_cnt reads 1.
- MMIO: write 32'h0000_01A5 to 32'h8000_0004 -> gpio_out=8'hA5 and readback=32'h000000A5. Write to 32'h8000_0000 -> cycle_cnt is not disturbed; two reads 5 cycles apart differ by 5.
- Read-during-write to 0x20 (old value 32'h1111_1111, new value 32'h2222_2222): macro off -> mem_data=32'h1111_1111 that cycle; macro on -> 32'h2222_2222.
- Reset mid-operation: assert rst=0 at CLEAR index 100, and again in RUN after RAM writes -> core_rst=1 asynchronously, gpio_out=0. RAM reads 0 after a full 256-cycle re-clear; mem_en pulses during CLEAR leave no trace.
- Saturation: preload store_cnt to 16'hFFFE via a hierarchical force, then do 3 RAM writes -> store_cnt reads 16'hFFFF.
